// File: rtl/conv_pkg.sv
// Shared convolution definitions: frame geometry, pixel/word widths, FSM encoding
// and the pixel clamp used by the row buffers and the ALU.
package conv_pkg;

    localparam int ROW_PIX = 28;
    localparam int ROWS    = 28;
    localparam int PIX_W   = 8;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Saturate a signed value into the unsigned 8-bit pixel range.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [31:0] t);
        if (t < 0)
            return '0;
        else if (t > 32'sd255)
            return {PIX_W{1'b1}};
        else
            return t[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/y_pack_buffer_if.sv
// ALU-result input and packed-word store handshakes of the output pack buffer.
interface y_pack_buffer_if
    import conv_pkg::*;
#(
    parameter int ACC_W          = 20,
    parameter int APB_ADDR_WIDTH = 13
) ();

    logic                      alu_valid;
    logic [ACC_W-1:0]          alu_acc;
    logic                      alu_ready;
    logic                      store_valid;
    logic                      store_ready;
    logic [WORD_W-1:0]         store_data;
    logic [APB_ADDR_WIDTH-1:0] store_addr;

    // slave is the pack buffer, master is the ALU / store-engine side.
    modport slave (
        input  alu_valid, alu_acc, store_ready,
        output alu_ready, store_valid, store_data, store_addr
    );

    modport master (
        output alu_valid, alu_acc, store_ready,
        input  alu_ready, store_valid, store_data, store_addr
    );

endinterface

// File: rtl/y_pack_buffer_word_fifo.sv
// Registered first-word-fall-through FIFO holding {addr, data} store entries.
module y_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 45,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; stale entries are never visible
    // because the consumer qualifies the head with empty.
    always_ff @(posedge clk) begin
        if (push_en && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/y_pack_buffer.sv
// Output pack buffer: clamps ALU results to pixels, packs 4 per word and queues
// each word with its byte address for the store engine.
module y_pack_buffer #(
    parameter int APB_ADDR_WIDTH = 13,
    parameter int ACC_W          = 20,
    parameter int SHIFT          = 0,
    parameter int ROW_PIX        = conv_pkg::ROW_PIX,
    parameter int ROWS           = conv_pkg::ROWS,
    parameter int FIFO_DEPTH     = 4,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    y_pack_buffer_if.slave  bus,
    output logic [4:0]      row_count,
    output logic            busy,
    output logic            frame_done
);

    import conv_pkg::*;

    localparam int PIX_CNT_W = $clog2(ROW_PIX);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W   = APB_ADDR_WIDTH + WORD_W;

    state_e                    state_q, state_d;
    logic [PIX_CNT_W-1:0]      pix_in_row;
    logic [4:0]                row_count_q;
    logic [WORD_W-1:0]         pack_q;
    logic [WORD_W-1:0]         word_next;
    logic [APB_ADDR_WIDTH-1:0] addr_q;

    logic signed [ACC_W-1:0]   acc_sh;
    logic [PIX_W-1:0]          pix;
    logic [1:0]                lane;
    logic                      accept;
    logic                      row_end;
    logic                      frame_end;
    logic                      push;
    logic                      pop;

    logic [ENTRY_W-1:0]        fifo_head;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;

    assign acc_sh    = $signed(bus.alu_acc) >>> SHIFT;
    assign pix       = clamp_pix(32'(acc_sh));
    assign lane      = pix_in_row[1:0];
    assign row_end   = (pix_in_row == PIX_CNT_W'(ROW_PIX - 1));
    assign frame_end = row_end && (row_count_q == 5'(ROWS - 1));

    // No pop look-ahead: a full FIFO stalls the ALU even while a word drains.
    assign bus.alu_ready = (state_q == ST_RUN) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept        = bus.alu_valid && bus.alu_ready;
    // start takes priority over a pixel offered in the same cycle.
    assign push          = accept && !start && ((lane == 2'd3) || row_end);
    assign pop           = bus.store_valid && bus.store_ready;

    always_comb begin
        word_next                = pack_q;
        word_next[lane*PIX_W +: PIX_W] = pix;
    end

    y_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start),
        .push      (push),
        .push_data ({addr_q, word_next}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.store_valid = !fifo_empty;
    assign bus.store_data  = fifo_empty ? '0 : fifo_head[WORD_W-1:0];
    assign bus.store_addr  = fifo_empty ? BASE_ADDR : fifo_head[ENTRY_W-1:WORD_W];

    assign row_count  = row_count_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: combinational blocks use blocking assignments with every output
    // defaulted first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_RUN:   if (accept && frame_end) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (start)
            state_d = ST_RUN;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_in_row  <= '0;
            row_count_q <= '0;
            pack_q      <= '0;
            addr_q      <= BASE_ADDR;
        end else if (start) begin
            pix_in_row  <= '0;
            row_count_q <= '0;
            pack_q      <= '0;
            addr_q      <= BASE_ADDR;
        end else if (accept) begin
            if (push) begin
                pack_q <= '0;
                addr_q <= addr_q + APB_ADDR_WIDTH'(4);
            end else begin
                pack_q <= word_next;
            end
            // Rows restart in lane 0 of a fresh word.
            if (row_end) begin
                pix_in_row  <= '0;
                row_count_q <= row_count_q + 5'd1;
            end else begin
                pix_in_row  <= pix_in_row + 1'b1;
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_y_pack_buffer.sv
// Scoreboard bench for y_pack_buffer: a 28x28 instance and a 30-pixel-row instance.
module tb_y_pack_buffer;

    localparam int AW    = 13;
    localparam int ACC_W = 20;

    typedef logic [AW+31:0] entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             start30 = 1'b0;
    logic             alu_valid = 1'b0;
    logic [ACC_W-1:0] alu_acc = '0;
    logic             store_ready = 1'b1;
    logic             store_ready30 = 1'b1;
    logic [4:0]       row_count, row_count30;
    logic             busy, busy30, frame_done, frame_done30;

    always #5 clk = ~clk;

    y_pack_buffer_if #(.ACC_W(ACC_W), .APB_ADDR_WIDTH(AW)) bus ();
    y_pack_buffer_if #(.ACC_W(ACC_W), .APB_ADDR_WIDTH(AW)) bus30 ();

    assign bus.alu_valid     = alu_valid;
    assign bus.alu_acc       = alu_acc;
    assign bus.store_ready   = store_ready;
    assign bus30.alu_valid   = alu_valid;
    assign bus30.alu_acc     = alu_acc;
    assign bus30.store_ready = store_ready30;

    y_pack_buffer #(.APB_ADDR_WIDTH(AW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .row_count(row_count), .busy(busy), .frame_done(frame_done)
    );

    y_pack_buffer #(.APB_ADDR_WIDTH(AW), .ACC_W(ACC_W), .ROW_PIX(30), .ROWS(2)) dut30 (
        .clk(clk), .rst(rst), .start(start30), .bus(bus30),
        .row_count(row_count30), .busy(busy30), .frame_done(frame_done30)
    );

    entry_t     q[$];
    entry_t     q30[$];
    entry_t     e_main, e_30;
    int         n_checks = 0;
    int         n_errors = 0;
    int         accepted = 0;
    int         words_seen = 0;
    int         done_cnt = 0;
    int         done30_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic          hold_prev = 1'b0;
    logic [31:0]   hold_data;
    logic [AW-1:0] hold_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_clamp(input int v);
        logic [31:0] t;
        t = v;
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return t[7:0];
    endfunction

    // Store-side monitor for the 28x28 instance: scoreboard pops and hold stability.
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && bus.store_valid) begin
                check("hold_data", bus.store_data, hold_data);
                check("hold_addr", bus.store_addr, hold_addr);
            end
            hold_prev = bus.store_valid && !bus.store_ready;
            hold_data = bus.store_data;
            hold_addr = bus.store_addr;
            if (bus.store_valid && bus.store_ready) begin
                check("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e_main = q.pop_front();
                    check("store_data", bus.store_data, e_main[31:0]);
                    check("store_addr", bus.store_addr, e_main[AW+31:32]);
                end
                words_seen++;
                last_addr = bus.store_addr;
            end
            if (frame_done) done_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus30.store_valid && bus30.store_ready) begin
                check("sb30_nonempty", q30.size() != 0, 1);
                if (q30.size() != 0) begin
                    e_30 = q30.pop_front();
                    check("store30_data", bus30.store_data, e_30[31:0]);
                    check("store30_addr", bus30.store_addr, e_30[AW+31:32]);
                end
            end
            if (frame_done30) done30_cnt++;
        end
    end

    // All steps start and end just after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit sel);
        if (sel) start30 = 1'b1; else start = 1'b1;
        tick(1);
        start   = 1'b0;
        start30 = 1'b0;
    endtask

    task automatic send_pix(input bit sel, input logic [ACC_W-1:0] acc);
        alu_acc   = acc;
        alu_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel ? bus30.alu_ready : bus.alu_ready) === 1'b1) begin
                @(posedge clk);
                #1;
                accepted++;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("alu_ready_timeout", sel ? bus30.alu_ready : bus.alu_ready, 1);
    endtask

    // Pixels p=(row*cols+col)&0xFF; words in the stalled tail are expected to be flushed.
    task automatic run_frame(input bit sel, input int rows, input int cols,
                             input int stall_tail, input bit do_start);
        logic [AW-1:0] m_addr;
        logic [31:0]   m_pack;
        int            p;
        bit            skip;
        if (do_start) pulse(sel);
        m_addr = '0;
        m_pack = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                p    = (r * cols + c) & 255;
                skip = (stall_tail > 0) && (r == rows - 1) && (c >= cols - stall_tail);
                if ((stall_tail > 0) && (r == rows - 1) && (c == cols - stall_tail + 1))
                    store_ready = 1'b0;
                m_pack[(c % 4) * 8 +: 8] = model_clamp(p);
                if ((c % 4 == 3) || (c == cols - 1)) begin
                    if (!skip) begin
                        if (sel) q30.push_back({m_addr, m_pack});
                        else     q.push_back({m_addr, m_pack});
                    end
                    m_addr = m_addr + 13'd4;
                    m_pack = '0;
                end
                send_pix(sel, ACC_W'(p));
            end
        end
        alu_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!(sel ? busy30 : busy)) break;
        end
        check("idle_timeout", sel ? busy30 : busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb_empty();
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        check("sb_drain", q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_store_valid", bus.store_valid, 0);
        check("rst_store_data",  bus.store_data, 0);
        check("rst_store_addr",  bus.store_addr, 0);
        check("rst_alu_ready",   bus.alu_ready, 0);
        check("rst_busy",        busy, 0);
        check("rst_row_count",   row_count, 0);
        check("rst_frame_done",  frame_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int words0;
    int acc0;

    initial begin
        // Reset state.
        #12;
        check_reset_outputs();
        check("rst30_store_valid", bus30.store_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);

        // 30-pixel rows: 8 words per row, last word carries pixels 28/29 only.
        run_frame(1'b1, 2, 30, 0, 1'b1);
        wait_idle(1'b1);
        check("t30_done_cnt", done30_cnt, 1);
        check("t30_row_count", row_count30, 2);
        check("t30_sb_empty", q30.size(), 0);

        // Asynchronous reset with 3 words queued.
        pulse(1'b0);
        store_ready = 1'b0;
        for (int i = 0; i < 12; i++) send_pix(1'b0, ACC_W'(i + 1));
        alu_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_before", bus.store_valid, 1);
        check("t1_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b1;
        store_ready = 1'b1;
        tick(1);

        // Clamp: -5, 0, 300, 0x7F.
        pulse(1'b0);
        q.push_back({13'h0, 32'h7FFF_0000});
        send_pix(1'b0, ACC_W'(-5));
        send_pix(1'b0, ACC_W'(0));
        send_pix(1'b0, ACC_W'(300));
        send_pix(1'b0, ACC_W'(127));
        alu_valid = 1'b0;
        wait_sb_empty();

        // Full frame with the store engine always ready (restarts the open frame).
        words0 = words_seen;
        run_frame(1'b0, 28, 28, 0, 1'b1);
        wait_idle(1'b0);
        check("t3_words", words_seen - words0, 196);
        check("t3_last_addr", last_addr, 13'h30C);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_row_count", row_count, 28);

        // Backpressure: 40 stalled cycles, 16 pixels fit into the FIFO.
        words0 = words_seen;
        store_ready = 1'b0;
        acc0 = accepted;
        fork
            run_frame(1'b0, 28, 28, 0, 1'b1);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                check("t5_accepted", accepted - acc0, 16);
                check("t5_alu_ready", bus.alu_ready, 0);
                check("t5_store_valid", bus.store_valid, 1);
                @(posedge clk);
                #1;
                store_ready = 1'b1;
            end
        join
        wait_idle(1'b0);
        check("t5_words", words_seen - words0, 196);
        check("t5_done_cnt", done_cnt, 2);

        // start during DRAIN with 2 words pending.
        run_frame(1'b0, 28, 28, 8, 1'b1);
        @(negedge clk);
        check("t6_busy_drain", busy, 1);
        check("t6_valid_pending", bus.store_valid, 1);
        check("t6_pending_addr", bus.store_addr, 13'h308);
        check("t6_row_count", row_count, 28);
        @(posedge clk);
        #1;
        pulse(1'b0);
        @(negedge clk);
        check("t6_flushed", bus.store_valid, 0);
        check("t6_row_cleared", row_count, 0);
        check("t6_busy_run", busy, 1);
        @(posedge clk);
        #1;
        store_ready = 1'b1;
        run_frame(1'b0, 28, 28, 0, 1'b0);
        wait_idle(1'b0);
        check("t6_done_cnt", done_cnt, 3);
        check("t6_sb_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
